// File: rtl/sram2s_param.sv
// sram2s_param: parametrised true dual-port synchronous SRAM with per-bit write
// mask, cross-port collision merge, selectable read-during-write behaviour,
// optional output register stage and a post-reset zero-fill engine.
//
// Ports:
//   CLK, RSTn              clock (rising edge), asynchronous active-low reset
//   CE0/A0/D0/WE0/WEM0     port 0 enable, address, write data, write enable, bit mask
//   Q0, QV0                port 0 read data and valid strobe
//   CE1/A1/D1/WE1/WEM1     port 1 request, same meaning as port 0
//   Q1, QV1                port 1 read data and valid strobe
//   BUSY                   clear engine running; port requests are ignored
//   COLL                   one-cycle pulse after both ports wrote the same address
module sram2s_param #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 7,
  parameter int DEPTH          = 128,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  output logic [DATA_W-1:0] Q0,
  output logic              QV0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] D1,
  input  logic              WE1,
  input  logic [DATA_W-1:0] WEM1,
  output logic [DATA_W-1:0] Q1,
  output logic              QV1,
  output logic              BUSY,
  output logic              COLL
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              busy;
  logic              ok0, ok1, wr0, wr1, same, coll;
  logic [ADDR_W-1:0] ix0, ix1;
  logic [DATA_W-1:0] old0, old1, new0, new1, rd0, rd1;

  logic [DATA_W-1:0] q0_s, q1_s;
  logic              qv0_s, qv1_s, coll_r;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                              input logic [DATA_W-1:0] d,
                                              input logic [DATA_W-1:0] m);
    return (w & ~m) | (d & m);
  endfunction

  always_comb begin
    busy = (state == CLEAR);
    ok0  = !busy && CE0 && ({1'b0, A0} < DEPTH_L);
    ok1  = !busy && CE1 && ({1'b0, A1} < DEPTH_L);
    wr0  = ok0 && WE0;
    wr1  = ok1 && WE1;
    same = (A0 == A1);
    coll = wr0 && wr1 && same;
    // Out-of-range requests index word 0 so the array is never read out of bounds.
    ix0  = ok0 ? A0 : '0;
    ix1  = ok1 ? A1 : '0;
    old0 = mem[ix0];
    old1 = mem[ix1];
    // Post-write word at each port's address: port 1 applied first, then
    // port 0 on top, which gives port 0 priority on overlapping mask bits.
    new0 = old0;
    if (wr1 && same) new0 = merge(new0, D1, WEM1);
    if (wr0)         new0 = merge(new0, D0, WEM0);
    new1 = old1;
    if (wr1)         new1 = merge(new1, D1, WEM1);
    if (wr0 && same) new1 = merge(new1, D0, WEM0);
    rd0 = '0;
    rd1 = '0;
    if (ok0) rd0 = (RDW_MODE != 0) ? new0 : old0;
    if (ok1) rd1 = (RDW_MODE != 0) ? new1 : old1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
      q0_s    <= '0;
      q1_s    <= '0;
      qv0_s   <= 1'b0;
      qv1_s   <= 1'b0;
      coll_r  <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        if (clr_cnt == LAST) begin
          state   <= READY;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
        end
      end
      coll_r <= coll;
      qv0_s  <= !busy && CE0;
      qv1_s  <= !busy && CE1;
      if (!busy && CE0) q0_s <= rd0;
      if (!busy && CE1) q1_s <= rd1;
    end
  end

  // Array storage has no reset; the clear engine zero-fills it word by word.
  always_ff @(posedge CLK) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr0) mem[A0] <= new0;
      if (wr1) mem[A1] <= new1;
    end
  end

  assign BUSY = busy;
  assign COLL = coll_r;

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        Q0  <= '0;
        Q1  <= '0;
        QV0 <= 1'b0;
        QV1 <= 1'b0;
      end else begin
        QV0 <= qv0_s;
        QV1 <= qv1_s;
        if (qv0_s) Q0 <= q0_s;
        if (qv1_s) Q1 <= q1_s;
      end
    end
  end else begin : g_noreg
    assign Q0  = q0_s;
    assign Q1  = q1_s;
    assign QV0 = qv0_s;
    assign QV1 = qv1_s;
  end

endmodule

// File: tb/tb_sram2s_param.sv
// Bench for sram2s_param: drives two instances with identical stimulus
// (k=0: defaults, 128 words, old-data RDW, latency 1;
//  k=1: 100 words, new-data RDW, output register, latency 2)
// and compares both against an array/queue model every cycle, plus literal checks.
module tb_sram2s_param;

  logic        CLK, RSTn;
  logic        ce0, we0, ce1, we1;
  logic [6:0]  a0, a1;
  logic [15:0] d0, m0, d1, m1;

  logic [15:0] q0 [2];
  logic [15:0] q1 [2];
  logic        qv0 [2];
  logic        qv1 [2];
  logic        busy [2];
  logic        coll [2];

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  sram2s_param #(.DATA_W(16), .ADDR_W(7), .DEPTH(128), .RDW_MODE(0), .OUT_REG(0),
                 .CLEAR_ON_RESET(1)) dut_a (
    .CLK(CLK), .RSTn(RSTn),
    .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .Q0(q0[0]), .QV0(qv0[0]),
    .CE1(ce1), .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .Q1(q1[0]), .QV1(qv1[0]),
    .BUSY(busy[0]), .COLL(coll[0]));

  sram2s_param #(.DATA_W(16), .ADDR_W(7), .DEPTH(100), .RDW_MODE(1), .OUT_REG(1),
                 .CLEAR_ON_RESET(1)) dut_b (
    .CLK(CLK), .RSTn(RSTn),
    .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(m0), .Q0(q0[1]), .QV0(qv0[1]),
    .CE1(ce1), .A1(a1), .D1(d1), .WE1(we1), .WEM1(m1), .Q1(q1[1]), .QV1(qv1[1]),
    .BUSY(busy[1]), .COLL(coll[1]));

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- behavioural model ----------------
  logic [15:0] mm [2][128];
  int          clr_left [2];
  logic [15:0] s_q0 [2], s_q1 [2], e_q0 [2], e_q1 [2];
  bit          s_v0 [2], s_v1 [2], e_v0 [2], e_v1 [2], e_busy [2], e_coll [2];

  function automatic int dep(input int k);
    return (k == 0) ? 128 : 100;
  endfunction

  task automatic model_reset(input int k);
    clr_left[k] = dep(k);
    s_q0[k] = '0; s_q1[k] = '0; s_v0[k] = 0; s_v1[k] = 0;
    e_q0[k] = '0; e_q1[k] = '0; e_v0[k] = 0; e_v1[k] = 0;
    e_busy[k] = 1; e_coll[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit ok0, ok1, w0, w1, v0, v1;
    logic [15:0] before0, before1, after0, after1, r0, r1;
    v0 = 0; v1 = 0; r0 = '0; r1 = '0;
    e_coll[k] = 0;
    if (clr_left[k] > 0) begin
      mm[k][dep(k) - clr_left[k]] = '0;
      clr_left[k]--;
    end else begin
      ok0 = ce0 && (int'(a0) < dep(k));
      ok1 = ce1 && (int'(a1) < dep(k));
      w0 = ok0 && we0;
      w1 = ok1 && we1;
      before0 = ok0 ? mm[k][a0] : 16'h0;
      before1 = ok1 ? mm[k][a1] : 16'h0;
      // apply port 1 then port 0 so port 0 wins shared mask bits
      if (w1) mm[k][a1] = (mm[k][a1] & ~m1) | (d1 & m1);
      if (w0) mm[k][a0] = (mm[k][a0] & ~m0) | (d0 & m0);
      after0 = ok0 ? mm[k][a0] : 16'h0;
      after1 = ok1 ? mm[k][a1] : 16'h0;
      v0 = ce0; v1 = ce1;
      r0 = (k == 1) ? after0 : before0;
      r1 = (k == 1) ? after1 : before1;
      e_coll[k] = w0 && w1 && (a0 == a1);
    end
    e_busy[k] = (clr_left[k] > 0);
    if (k == 1) begin
      if (s_v0[k]) e_q0[k] = s_q0[k];
      if (s_v1[k]) e_q1[k] = s_q1[k];
      e_v0[k] = s_v0[k]; e_v1[k] = s_v1[k];
      s_v0[k] = v0; s_v1[k] = v1;
      if (v0) s_q0[k] = r0;
      if (v1) s_q1[k] = r1;
    end else begin
      if (v0) e_q0[k] = r0;
      if (v1) e_q1[k] = r1;
      e_v0[k] = v0; e_v1[k] = v1;
    end
  endtask

  always @(posedge CLK or negedge RSTn) begin
    for (int k = 0; k < 2; k++) begin
      if (!RSTn) model_reset(k);
      else model_step(k);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d_q0", k), 32'(q0[k]), 32'(e_q0[k]));
        chk($sformatf("m%0d_qv0", k), 32'(qv0[k]), 32'(e_v0[k]));
        chk($sformatf("m%0d_q1", k), 32'(q1[k]), 32'(e_q1[k]));
        chk($sformatf("m%0d_qv1", k), 32'(qv1[k]), 32'(e_v1[k]));
        chk($sformatf("m%0d_busy", k), 32'(busy[k]), 32'(e_busy[k]));
        chk($sformatf("m%0d_coll", k), 32'(coll[k]), 32'(e_coll[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    ce0 = 0; we0 = 0; ce1 = 0; we1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; m0 = '0; m1 = '0;
  endtask

  task automatic p0(input bit we, input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
    ce0 = 1; we0 = we; a0 = a; d0 = d; m0 = m;
  endtask

  task automatic p1(input bit we, input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
    ce1 = 1; we1 = we; a1 = a; d1 = d; m1 = m;
  endtask

  task automatic clear_run();
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (k == 9)  p0(1, 7'd5, 16'hFFFF, 16'hFFFF);
      if (k == 10) idle();
      if (k == 99)  chk("b_busy_99", 32'(busy[1]), 32'd1);
      if (k == 100) chk("b_busy_100", 32'(busy[1]), 32'd0);
      if (k == 127) chk("a_busy_127", 32'(busy[0]), 32'd1);
      if (k == 128) chk("a_busy_128", 32'(busy[0]), 32'd0);
    end
  endtask

  logic [15:0] acc;
  int          nv;

  initial begin
    RSTn = 0;
    idle();
    tick();
    armed = 1;
    tick();
    chk("rst_busy", 32'(busy[0]), 32'd1);
    chk("rst_q0", 32'(q0[0]), 32'd0);
    tick();
    RSTn = 1;
    clear_run();

    // reads after clear, including the address written while busy
    p0(0, 7'd0, '0, '0); tick(); chk("clr_rd0", 32'(q0[0]), 32'h0);
    p0(0, 7'd5, '0, '0); tick(); chk("clr_rd5", 32'(q0[0]), 32'h0);
    p0(0, 7'd127, '0, '0); tick(); chk("clr_rd127", 32'(q0[0]), 32'h0);
    chk("clr_rd127_v", 32'(qv0[0]), 32'd1);
    idle(); tick();

    // masked write
    p0(1, 7'd3, 16'h1234, 16'hFFFF); tick();
    p0(1, 7'd3, 16'hABCD, 16'h00FF); tick();
    idle(); p1(0, 7'd3, '0, '0); tick();
    chk("mask_a_q1", 32'(q1[0]), 32'h12CD);
    chk("mask_a_qv1", 32'(qv1[0]), 32'd1);
    chk("mask_b_qv1_early", 32'(qv1[1]), 32'd0);
    idle(); tick();
    chk("mask_b_q1", 32'(q1[1]), 32'h12CD);
    chk("mask_b_qv1", 32'(qv1[1]), 32'd1);

    // cross-port read during write
    p0(1, 7'd7, 16'h0001, 16'hFFFF); tick();
    p0(1, 7'd7, 16'h0002, 16'hFFFF); p1(0, 7'd7, '0, '0); tick();
    chk("rdw_old", 32'(q1[0]), 32'h0001);
    idle(); tick();
    chk("rdw_new", 32'(q1[1]), 32'h0002);

    // write-write collision
    p0(1, 7'd9, 16'hAAAA, 16'hFF00); p1(1, 7'd9, 16'h5555, 16'hFFFF); tick();
    chk("coll_pulse", 32'(coll[0]), 32'd1);
    idle(); tick();
    chk("coll_end", 32'(coll[0]), 32'd0);
    p1(0, 7'd9, '0, '0); tick();
    chk("coll_merge", 32'(q1[0]), 32'hAA55);
    idle(); tick();

    // out-of-range on the 100-word instance, then alias check at 20
    p0(1, 7'd120, 16'hBEEF, 16'hFFFF); tick();
    idle(); p1(0, 7'd120, '0, '0); tick();
    chk("oor_a_q1", 32'(q1[0]), 32'hBEEF);
    p1(0, 7'd20, '0, '0); tick();
    chk("oor_b_q1", 32'(q1[1]), 32'h0);
    chk("oor_b_qv1", 32'(qv1[1]), 32'd1);
    idle(); tick();

    // idle cycles hold data
    p1(0, 7'd3, '0, '0); tick();
    idle();
    tick(); tick(); tick();
    chk("idle_a_q1", 32'(q1[0]), 32'h12CD);
    chk("idle_a_qv1", 32'(qv1[0]), 32'd0);
    chk("idle_b_q1", 32'(q1[1]), 32'h12CD);
    chk("idle_b_qv1", 32'(qv1[1]), 32'd0);

    // reset in the middle of a clear
    RSTn = 0; tick(); RSTn = 1;
    for (int i = 0; i < 50; i++) tick();
    chk("mid_busy", 32'(busy[0]), 32'd1);
    RSTn = 0; tick(); RSTn = 1;
    clear_run();

    acc = '0; nv = 0;
    for (int i = 0; i < 128; i++) begin
      p0(0, 7'(i), '0, '0); p1(0, 7'(127 - i), '0, '0); tick();
      acc = acc | q0[0] | q1[0];
      if (qv0[0] && qv1[0]) nv++;
    end
    idle(); tick(); tick();
    chk("sweep_zero", 32'(acc), 32'h0);
    chk("sweep_valid", 32'(nv), 32'd128);

    armed = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
